command_sequencer: RTL
======================

Name: command_sequencer

Overview:
- Top-level control for the image processor.
- Parses the UART command frame, forwards encoded-image bytes to the JPEG decoder, starts the filter/histogram engine in the selected mode, then streams the result RAM back out through the UART transmitter.
- Sits between uart_rx/uart_tx and the decoder, filter, image RAM and histogram RAM.

Parameters:
- IMAGE_WIDTH, 128, pixels per row of the image RAM.
- IMAGE_HEIGHT, 128, rows of the image RAM.
- HISTOGRAM_RAM_ADDRESS_WIDTH, 8, histogram has 2**this 8-bit bins.
- RD_ADDR_WIDTH, 14, width of the read address; must satisfy 2**RD_ADDR_WIDTH >= IMAGE_WIDTH*IMAGE_HEIGHT.
- TIMEOUT_CYCLES, 1_000_000, idle limit in LOAD; used only with LOAD_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- rx_data  in  8  received UART byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
- dec_data  out  8  byte to the decoder.
- dec_valid  out  1  one-cycle strobe to the decoder.
- dec_done  in  1  pulse: decoder has written the full image to RAM.
- filter_mode  out  3  1=edge detect, 2=edge enhance, 3=noise filter, 4=histogram statistics, 5=histogram equalization, 6=boundary extraction.
- filter_start  out  1  one-cycle start pulse.
- filter_done  in  1  pulse: filter or histogram result is complete.
- rd_sel  out  1  0=image RAM, 1=histogram RAM.
- rd_addr  out  RD_ADDR_WIDTH  RAM read address; rd_data is valid 1 cycle later.
- rd_data  in  8  RAM read data.
- tx_data  out  8  byte to uart_tx.
- tx_start  out  1  one-cycle send strobe.
- tx_busy  in  1  uart_tx is busy.
- busy  out  1  high in every state except IDLE.
- err_cmd  out  1  sticky bad-command flag; cleared only by rst or a valid header.

Behaviour:
- Reset: all outputs 0; state IDLE; filter_mode=0; counters 0. An asserted rst aborts any operation immediately.
- Command frame is sent big-endian: CD BA, then C0 A0 for command C in 1..6.
- IDLE: rx byte 0xCD -> HDR1; any other byte is ignored.
- HDR1:
  - 0xBA -> CMD0, and err_cmd clears.
  - 0xCD -> stay in HDR1.
  - any other byte -> IDLE.
- CMD0: latch byte b. b[3:0] must be 0 and b[7:4] must be in 1..6. Next byte -> CMD1.
- CMD1:
  - Byte == 0xA0 and b valid -> filter_mode = b[7:4], go to LOAD.
  - Otherwise -> err_cmd=1, go to IDLE.
- LOAD:
  - Each rx_valid produces dec_data=rx_data and dec_valid=1 on the next cycle (1-cycle latency), with no drops.
  - dec_done -> START. If dec_done and rx_valid arrive in the same cycle, that byte is still forwarded.
- START: filter_start=1 for exactly one cycle -> WAIT.
- WAIT:
  - filter_done -> SEND, with rd_addr=0.
  - rd_sel=1 if filter_mode==4, else 0.
  - Total count N = 2**HISTOGRAM_RAM_ADDRESS_WIDTH for histogram, else IMAGE_WIDTH*IMAGE_HEIGHT.
- SEND, per byte:
  1. Present rd_addr and wait 1 cycle.
  2. When tx_busy==0, capture tx_data=rd_data and pulse tx_start.
  3. Wait for tx_busy to rise, then fall.
  4. Increment rd_addr.
  - Addresses go 0..N-1 in raster order; rd_addr does not wrap.
  - After byte N-1 completes -> IDLE.
- rx_valid outside IDLE/HDR1/CMD0/CMD1/LOAD is ignored (no decoder traffic, no state change).
- filter_done outside WAIT and dec_done outside LOAD are ignored.

Optional Feature:
- Macro LOAD_TIMEOUT_EN.
- With the macro: a counter runs in LOAD, resets on every rx_valid, and saturates. Reaching TIMEOUT_CYCLES -> IDLE and err_cmd=1; filter_start is never issued.
- Without the macro: LOAD waits indefinitely for dec_done.

Decomposition:
- Package image_processor_pkg holds:
  - header bytes 0xCD and 0xBA, trailer byte 0xA0;
  - command code constants 1..6;
  - the state enum (IDLE, HDR1, CMD0, CMD1, LOAD, START, WAIT, SEND).
- One sub-module, result_streamer: takes start, rd_sel, count N and drives the rd_addr/tx_start/tx_busy handshake, returning done.

Test Plan:
- Send CD BA 10 A0, then 3 bytes, then dec_done -> filter_mode=1; dec_valid pulses 3 times with matching data; exactly one filter_start pulse.
- Send CD BA 40 A0 + dec_done, then filter_done with model uart_tx busy for 20 cycles per byte -> 256 tx_start pulses; rd_sel=1; tx_data[i] == hist_ram[i].
- Send CD BA 70 A0 -> err_cmd=1, back to IDLE, no dec_valid. A following CD BA -> err_cmd=0.
- Send CD CD BA 20 A0 -> accepted as edge enhance (repeated 0xCD handled).
- Command 30 A0 with 4x4 image: after filter_done, 16 bytes sent in raster order, busy=0 afterwards. Assert rst at byte 7 -> tx_start stops, all outputs 0.
- LOAD_TIMEOUT_EN with TIMEOUT_CYCLES=100: header + command, then silence -> IDLE and err_cmd=1 after 100 cycles.

Source files
------------

// File: rtl/image_processor_pkg.sv
// Shared constants and state types for the image processor command path.
// Header/trailer bytes, command codes, sequencer and streamer states.
package image_processor_pkg;

   localparam logic [7:0] HDR_BYTE0 = 8'hCD;
   localparam logic [7:0] HDR_BYTE1 = 8'hBA;
   localparam logic [7:0] TRL_BYTE  = 8'hA0;

   localparam logic [2:0] MODE_EDGE_DETECT  = 3'd1;
   localparam logic [2:0] MODE_EDGE_ENHANCE = 3'd2;
   localparam logic [2:0] MODE_NOISE_FILTER = 3'd3;
   localparam logic [2:0] MODE_HIST_STATS   = 3'd4;
   localparam logic [2:0] MODE_HIST_EQUAL   = 3'd5;
   localparam logic [2:0] MODE_BOUNDARY     = 3'd6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR1,
      ST_CMD0,
      ST_CMD1,
      ST_LOAD,
      ST_START,
      ST_WAIT,
      ST_SEND
   } state_t;

   typedef enum logic [2:0] {
      SS_IDLE,
      SS_ADDR,
      SS_SEND,
      SS_RISE,
      SS_FALL
   } stream_state_t;

   // Command byte is C0 with C a known filter mode.
   function automatic logic cmd_ok(input logic [7:0] b);
      return (b[3:0] == 4'h0)
          && (b[7:4] >= {1'b0, MODE_EDGE_DETECT})
          && (b[7:4] <= {1'b0, MODE_BOUNDARY});
   endfunction

endpackage

// File: rtl/result_streamer.sv
// Streams result RAM bytes 0..N-1 out through the UART transmitter,
// one byte per full tx_busy rise/fall handshake.
module result_streamer
   import image_processor_pkg::*;
#(
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              sel_i,
   input  logic [ADDR_W:0]   count,
   output logic              done,
   output logic              rd_sel,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [7:0]        rd_data,
   output logic [7:0]        tx_data,
   output logic              tx_start,
   input  logic              tx_busy
);

   stream_state_t     state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic              tx_start_q, tx_start_d;
   logic [ADDR_W:0]   addr_nxt;

   assign addr_nxt = {1'b0, addr_q} + (ADDR_W + 1)'(1);
   assign rd_sel   = sel_i;
   assign rd_addr  = addr_q;
   assign tx_data  = tx_data_q;
   assign tx_start = tx_start_q;

   // Per-byte handshake: address, read, send, wait busy rise then fall.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      count_d    = count_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      done       = 1'b0;
      unique case (state_q)
         SS_IDLE: begin
            if (start) begin
               addr_d  = '0;
               count_d = count;
               state_d = SS_ADDR;
            end
         end
         SS_ADDR: state_d = SS_SEND;
         SS_SEND: begin
            if (!tx_busy) begin
               tx_data_d  = rd_data;
               tx_start_d = 1'b1;
               state_d    = SS_RISE;
            end
         end
         SS_RISE: begin
            if (tx_busy) state_d = SS_FALL;
         end
         SS_FALL: begin
            if (!tx_busy) begin
               if (addr_nxt == count_q) begin
                  done    = 1'b1;
                  state_d = SS_IDLE;
               end else begin
                  addr_d  = addr_nxt[ADDR_W-1:0];
                  state_d = SS_ADDR;
               end
            end
         end
         default: state_d = SS_IDLE;
      endcase
   end

   // Streamer state and registered UART outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= SS_IDLE;
         addr_q     <= '0;
         count_q    <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         count_q    <= count_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
      end
   end

endmodule

// File: rtl/command_sequencer.sv
// Top-level command parser/sequencer for the image processor.
// Optional LOAD idle timeout enabled by defining LOAD_TIMEOUT_EN.
module command_sequencer
   import image_processor_pkg::*;
#(
   parameter int IMAGE_WIDTH                 = 128,
   parameter int IMAGE_HEIGHT                = 128,
   parameter int HISTOGRAM_RAM_ADDRESS_WIDTH = 8,
   parameter int RD_ADDR_WIDTH               = 14,
   parameter int TIMEOUT_CYCLES              = 1_000_000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [7:0]               rx_data,
   input  logic                     rx_valid,
   output logic [7:0]               dec_data,
   output logic                     dec_valid,
   input  logic                     dec_done,
   output logic [2:0]               filter_mode,
   output logic                     filter_start,
   input  logic                     filter_done,
   output logic                     rd_sel,
   output logic [RD_ADDR_WIDTH-1:0] rd_addr,
   input  logic [7:0]               rd_data,
   output logic [7:0]               tx_data,
   output logic                     tx_start,
   input  logic                     tx_busy,
   output logic                     busy,
   output logic                     err_cmd
);

   localparam int CNT_W = RD_ADDR_WIDTH + 1;
   localparam logic [CNT_W-1:0] IMG_N =
      CNT_W'(IMAGE_WIDTH * IMAGE_HEIGHT);
   localparam logic [CNT_W-1:0] HIST_N =
      CNT_W'(1 << HISTOGRAM_RAM_ADDRESS_WIDTH);

   if ((TIMEOUT_CYCLES < 1)
      || (HISTOGRAM_RAM_ADDRESS_WIDTH > RD_ADDR_WIDTH)
      || ((longint'(1) << RD_ADDR_WIDTH)
          < longint'(IMAGE_WIDTH) * longint'(IMAGE_HEIGHT)))
   begin : g_bad_params
      $error("command_sequencer: inconsistent parameters");
   end

   state_t     state_q, state_d;
   logic [7:0] cmd_q, cmd_d;
   logic [2:0] mode_q, mode_d;
   logic       err_q, err_d;
   logic [7:0] dec_data_q, dec_data_d;
   logic       dec_valid_q, dec_valid_d;
   logic       stream_start, stream_done, hist_sel;
   logic [CNT_W-1:0] count_n;

`ifdef LOAD_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);
   logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

   assign hist_sel     = (mode_q == MODE_HIST_STATS);
   assign count_n      = hist_sel ? HIST_N : IMG_N;
   assign filter_mode  = mode_q;
   assign filter_start = (state_q == ST_START);
   assign busy         = (state_q != ST_IDLE);
   assign err_cmd      = err_q;
   assign dec_data     = dec_data_q;
   assign dec_valid    = dec_valid_q;

   // Frame parsing, decoder forwarding and job sequencing.
   always_comb begin
      state_d      = state_q;
      cmd_d        = cmd_q;
      mode_d       = mode_q;
      err_d        = err_q;
      dec_data_d   = dec_data_q;
      dec_valid_d  = 1'b0;
      stream_start = 1'b0;
`ifdef LOAD_TIMEOUT_EN
      tmo_d        = '0;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (rx_valid && rx_data == HDR_BYTE0) state_d = ST_HDR1;
         end
         ST_HDR1: begin
            if (rx_valid) begin
               unique case (1'b1)
                  (rx_data == HDR_BYTE1): begin
                     err_d   = 1'b0;
                     state_d = ST_CMD0;
                  end
                  (rx_data == HDR_BYTE0): state_d = ST_HDR1;
                  default:                state_d = ST_IDLE;
               endcase
            end
         end
         ST_CMD0: begin
            if (rx_valid) begin
               cmd_d   = rx_data;
               state_d = ST_CMD1;
            end
         end
         ST_CMD1: begin
            if (rx_valid) begin
               if (rx_data == TRL_BYTE && cmd_ok(cmd_q)) begin
                  mode_d  = cmd_q[6:4];
                  state_d = ST_LOAD;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
         ST_LOAD: begin
            if (rx_valid) begin
               dec_valid_d = 1'b1;
               dec_data_d  = rx_data;
            end
`ifdef LOAD_TIMEOUT_EN
            if (rx_valid)             tmo_d = '0;
            else if (tmo_q != TMO_MAX) tmo_d = tmo_q + TMO_W'(1);
            else                      tmo_d = tmo_q;
            if (dec_done) begin
               state_d = ST_START;
            end else if (!rx_valid && tmo_q == TMO_MAX) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end
`else
            if (dec_done) state_d = ST_START;
`endif
         end
         ST_START: state_d = ST_WAIT;
         ST_WAIT: begin
            if (filter_done) begin
               stream_start = 1'b1;
               state_d      = ST_SEND;
            end
         end
         ST_SEND: begin
            if (stream_done) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Sequencer state, latched command and decoder outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cmd_q       <= '0;
         mode_q      <= '0;
         err_q       <= 1'b0;
         dec_data_q  <= '0;
         dec_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         mode_q      <= mode_d;
         err_q       <= err_d;
         dec_data_q  <= dec_data_d;
         dec_valid_q <= dec_valid_d;
      end
   end

`ifdef LOAD_TIMEOUT_EN
   // Saturating LOAD idle counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) tmo_q <= '0;
      else     tmo_q <= tmo_d;
   end
`endif

   result_streamer #(
      .ADDR_W (RD_ADDR_WIDTH)
   ) u_streamer (
      .clk      (clk),
      .rst      (rst),
      .start    (stream_start),
      .sel_i    (hist_sel),
      .count    (count_n),
      .done     (stream_done),
      .rd_sel   (rd_sel),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .tx_data  (tx_data),
      .tx_start (tx_start),
      .tx_busy  (tx_busy)
   );

endmodule
